sobel_threshold_ctrl: RTL and testbench

Frame-synchronous threshold controller for the Sobel edge detector. It watches the detector's output stream and counts edge pixels and valid pixels in each frame. At each frame end it computes the next threshold, either adaptively (keeping the edge count inside a target window) or from a manual value. The new threshold is applied only at the next frame start, so it never changes mid-frame. Instantiated beside the Sobel detector; `sobel_threshold` drives the detector's threshold input.

---
 rtl/sobel_ctrl_pkg.sv | 32 +++
 rtl/sobel_frame_counter.sv | 52 +++++
 rtl/sobel_threshold_ctrl.sv | 147 ++++++++++++++
 tb/tb_sobel_threshold_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_ctrl_pkg.sv
// Shared types and helpers for the Sobel threshold controller.
package sobel_ctrl_pkg;

    typedef enum logic [1:0] {
        StWaitSof,
        StCount,
        StEval,
        StDone
    } state_t;

    typedef logic [7:0] thr_t;

    // Clamps a signed 10-bit intermediate threshold into [lo, hi]; the extra bits make
    // both overflow above 255 and underflow below 0 land on the correct bound.
    function automatic thr_t thr_clamp(input logic signed [9:0] val, input thr_t lo,
                                       input thr_t hi);
        logic signed [9:0] lo_s;
        logic signed [9:0] hi_s;
        thr_t              res;
        lo_s = $signed({2'b00, lo});
        hi_s = $signed({2'b00, hi});
        if (val < lo_s) begin
            res = lo;
        end else if (val > hi_s) begin
            res = hi;
        end else begin
            res = val[7:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/sobel_frame_counter.sv
// Vsync edge detection plus saturating per-frame pixel and edge-pixel counters.
module sobel_frame_counter #(
    parameter int unsigned CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vsync,
    input  logic             href,
    input  logic             edge_bit,
    input  logic             clr,
    input  logic             cnt_en,
    output logic             sof,
    output logic             eof,
    output logic [CNT_W-1:0] pix_cnt,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic vs_d;

    // Resetting to 1 hides a frame already active at reset release: no SOF fires
    // until vsync has been seen low, and a stray EOF is ignored in WAIT_SOF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d <= 1'b1;
        end else begin
            vs_d <= vsync;
        end
    end

    assign sof = vsync & ~vs_d;
    assign eof = ~vsync & vs_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt  <= '0;
            edge_cnt <= '0;
        end else if (clr) begin
            pix_cnt  <= '0;
            edge_cnt <= '0;
        end else if (cnt_en && href) begin
            if (pix_cnt != CNT_MAX) begin
                pix_cnt <= pix_cnt + CNT_W'(1);
            end
            if (edge_bit && (edge_cnt != CNT_MAX)) begin
                edge_cnt <= edge_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sobel_threshold_ctrl.sv
// Frame-synchronous threshold controller for the Sobel detector (adaptive or manual).
// Optional SOBEL_THR_STATS_EN exposes the last evaluated frame's pixel/edge counts.
module sobel_threshold_ctrl
    import sobel_ctrl_pkg::*;
#(
    parameter logic [10:0] IMG_HDISP = 11'd640,
    parameter logic [10:0] IMG_VDISP = 11'd480,
    parameter int unsigned CNT_W     = 20,
    parameter thr_t        THR_INIT  = 8'd64,
    parameter thr_t        THR_MIN   = 8'd16,
    parameter thr_t        THR_MAX   = 8'd240,
    parameter thr_t        THR_STEP  = 8'd4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             post_frame_vsync,
    input  logic             post_frame_href,
    input  logic             post_img_Bit,
    input  logic             auto_en,
    input  logic [7:0]       manual_thr,
    input  logic [CNT_W-1:0] cfg_target_lo,
    input  logic [CNT_W-1:0] cfg_target_hi,
`ifdef SOBEL_THR_STATS_EN
    output logic [CNT_W-1:0] last_edge_cnt,
    output logic [CNT_W-1:0] last_pix_cnt,
`endif
    output logic [7:0]       sobel_threshold,
    output logic             frame_done,
    output logic             frame_err
);

    localparam int unsigned FRAME_PIX = int'(IMG_HDISP) * int'(IMG_VDISP);

    state_t           state;
    thr_t             pending;
    thr_t             pending_nxt;
    logic             sof_pend;
    logic             sof;
    logic             eof;
    logic             cnt_clr;
    logic             cnt_en;
    logic             pix_bad;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic signed [9:0] thr_up;
    logic signed [9:0] thr_dn;

    // Counters restart whenever a new frame is committed, including the latched-SOF path.
    assign cnt_clr = ((state == StWaitSof) && sof) ||
                     ((state == StDone) && (sof || sof_pend));
    assign cnt_en  = (state == StCount);

    sobel_frame_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .vsync    (post_frame_vsync),
        .href     (post_frame_href),
        .edge_bit (post_img_Bit),
        .clr      (cnt_clr),
        .cnt_en   (cnt_en),
        .sof      (sof),
        .eof      (eof),
        .pix_cnt  (pix_cnt),
        .edge_cnt (edge_cnt)
    );

    always_comb begin
        pix_bad     = (32'(pix_cnt) != FRAME_PIX);
        thr_up      = $signed({2'b00, sobel_threshold}) + $signed({2'b00, THR_STEP});
        thr_dn      = $signed({2'b00, sobel_threshold}) - $signed({2'b00, THR_STEP});
        pending_nxt = pending;
        if (pix_bad) begin
            pending_nxt = pending;
        end else if (!auto_en) begin
            pending_nxt = thr_clamp($signed({2'b00, manual_thr}), THR_MIN, THR_MAX);
        end else if (cfg_target_lo > cfg_target_hi) begin
            pending_nxt = pending;
        end else if (edge_cnt > cfg_target_hi) begin
            pending_nxt = thr_clamp(thr_up, THR_MIN, THR_MAX);
        end else if (edge_cnt < cfg_target_lo) begin
            pending_nxt = thr_clamp(thr_dn, THR_MIN, THR_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= StWaitSof;
            sobel_threshold <= THR_INIT;
            pending         <= THR_INIT;
            frame_done      <= 1'b0;
            frame_err       <= 1'b0;
            sof_pend        <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            unique case (state)
                StWaitSof: begin
                    if (sof) begin
                        sobel_threshold <= pending;
                        state           <= StCount;
                    end
                end
                StCount: begin
                    if (eof) begin
                        state <= StEval;
                    end
                end
                StEval: begin
                    pending    <= pending_nxt;
                    frame_done <= 1'b1;
                    frame_err  <= pix_bad;
                    if (sof) begin
                        sof_pend <= 1'b1;
                    end
                    state <= StDone;
                end
                StDone: begin
                    sof_pend <= 1'b0;
                    // A short vsync gap may have started the next frame already.
                    if (sof || sof_pend) begin
                        sobel_threshold <= pending;
                        state           <= StCount;
                    end else begin
                        state <= StWaitSof;
                    end
                end
                default: state <= StWaitSof;
            endcase
        end
    end

`ifdef SOBEL_THR_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_edge_cnt <= '0;
            last_pix_cnt  <= '0;
        end else if (state == StEval) begin
            last_edge_cnt <= edge_cnt;
            last_pix_cnt  <= pix_cnt;
        end
    end
`else
`endif

endmodule

// File: tb/tb_sobel_threshold_ctrl.sv
// Directed self-checking bench for sobel_threshold_ctrl using a reduced 16x8 frame.
module tb_sobel_threshold_ctrl;

    localparam int HD    = 16;
    localparam int VD    = 8;
    localparam int CNT_W = 20;

    logic             clk;
    logic             rst_n;
    logic             vsync;
    logic             href;
    logic             bitv;
    logic             auto_en;
    logic [7:0]       manual_thr;
    logic [CNT_W-1:0] tlo;
    logic [CNT_W-1:0] thi;
    logic [7:0]       thr;
    logic             done;
    logic             err;
`ifdef SOBEL_THR_STATS_EN
    logic [CNT_W-1:0] last_edge;
    logic [CNT_W-1:0] last_pix;
`endif

    int errors = 0;
    int checks = 0;

    sobel_threshold_ctrl #(
        .IMG_HDISP (11'd16),
        .IMG_VDISP (11'd8),
        .CNT_W     (CNT_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .post_frame_vsync (vsync),
        .post_frame_href  (href),
        .post_img_Bit     (bitv),
        .auto_en          (auto_en),
        .manual_thr       (manual_thr),
        .cfg_target_lo    (tlo),
        .cfg_target_hi    (thi),
`ifdef SOBEL_THR_STATS_EN
        .last_edge_cnt    (last_edge),
        .last_pix_cnt     (last_pix),
`endif
        .sobel_threshold  (thr),
        .frame_done       (done),
        .frame_err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [7:0] exp_thr);
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        check("thr_apply", 32'(thr), 32'(exp_thr));
    endtask

    // First `edges` valid pixels of the call carry the edge flag.
    task automatic drive_lines(input int lines, input int edges);
        int idx;
        idx = 0;
        repeat (2) @(negedge clk);
        for (int l = 0; l < lines; l++) begin
            for (int p = 0; p < HD; p++) begin
                @(negedge clk);
                href = 1'b1;
                bitv = (idx < edges);
                idx++;
            end
            @(negedge clk);
            href = 1'b0;
            bitv = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic end_frame(input logic exp_err);
        @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        check("done_early", 32'(done), 32'd0);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd1);
        check("err_pulse", 32'(err), 32'(exp_err));
        @(negedge clk);
        check("done_width", 32'(done), 32'd0);
        check("err_width", 32'(err), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        vsync      = 1'b1;
        href       = 1'b0;
        bitv       = 1'b0;
        auto_en    = 1'b1;
        manual_thr = 8'd0;
        tlo        = 20'd10;
        thi        = 20'd20;

        // Reset values, with a frame already active at reset release.
        repeat (3) @(negedge clk);
        check("rst_thr", 32'(thr), 32'd64);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
`ifdef SOBEL_THR_STATS_EN
        check("rst_last_edge", 32'(last_edge), 32'd0);
        check("rst_last_pix", 32'(last_pix), 32'd0);
`endif
        rst_n = 1'b1;
        drive_lines(2, 3);
        @(negedge clk);
        vsync = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_done_partial", 32'(done), 32'd0);
        end

        // Adaptive raise: 50 edges > 20 -> 64 + 4.
        start_frame(8'd64);
        drive_lines(VD, 50);
        end_frame(1'b0);
`ifdef SOBEL_THR_STATS_EN
        check("last_edge", 32'(last_edge), 32'd50);
        check("last_pix", 32'(last_pix), 32'd128);
`endif

        // Manual 250 clamps to 240.
        start_frame(8'd68);
        auto_en    = 1'b0;
        manual_thr = 8'd250;
        drive_lines(VD, 0);
        end_frame(1'b0);

        // Manual 18.
        start_frame(8'd240);
        manual_thr = 8'd18;
        drive_lines(VD, 0);
        end_frame(1'b0);

        // Adaptive lower from 18: clamps to 16.
        start_frame(8'd18);
        auto_en = 1'b1;
        drive_lines(VD, 5);
        end_frame(1'b0);

        // Adaptive lower at 16 stays at 16.
        start_frame(8'd16);
        drive_lines(VD, 5);
        end_frame(1'b0);

        // auto_en toggled mid-frame: only the EVAL value (manual 100) matters.
        start_frame(8'd16);
        auto_en    = 1'b1;
        manual_thr = 8'd7;
        drive_lines(VD / 2, 0);
        auto_en    = 1'b0;
        manual_thr = 8'd100;
        drive_lines(VD / 2, 0);
        end_frame(1'b0);

        // Manual 238, then adaptive raise clamps to 240.
        start_frame(8'd100);
        manual_thr = 8'd238;
        drive_lines(VD, 0);
        end_frame(1'b0);
        start_frame(8'd238);
        auto_en = 1'b1;
        drive_lines(VD, 50);
        end_frame(1'b0);

        // Back to manual 100, then in-window count leaves it unchanged.
        start_frame(8'd240);
        auto_en    = 1'b0;
        manual_thr = 8'd100;
        drive_lines(VD, 0);
        end_frame(1'b0);
        start_frame(8'd100);
        auto_en = 1'b1;
        drive_lines(VD, 15);
        end_frame(1'b0);

        // Short frame (7 lines): error pulse, threshold unchanged despite manual 50.
        start_frame(8'd100);
        auto_en    = 1'b0;
        manual_thr = 8'd50;
        drive_lines(VD - 1, 0);
        end_frame(1'b1);
`ifdef SOBEL_THR_STATS_EN
        check("last_pix_short", 32'(last_pix), 32'd112);
`endif

        // Invalid window (lo > hi): unchanged.
        start_frame(8'd100);
        auto_en = 1'b1;
        tlo     = 20'd30;
        thi     = 20'd20;
        drive_lines(VD, 50);
        end_frame(1'b0);

        // Back-to-back frames with a single-cycle vsync gap.
        start_frame(8'd100);
        tlo = 20'd10;
        thi = 20'd20;
        drive_lines(VD, 50);
        @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        vsync = 1'b1;
        check("b2b_done_early", 32'(done), 32'd0);
        @(negedge clk);
        check("b2b_done", 32'(done), 32'd1);
        check("b2b_err", 32'(err), 32'd0);
        @(negedge clk);
        check("b2b_thr", 32'(thr), 32'd104);
        check("b2b_done_width", 32'(done), 32'd0);
        drive_lines(VD, 60);
        end_frame(1'b0);
`ifdef SOBEL_THR_STATS_EN
        check("b2b_last_edge", 32'(last_edge), 32'd60);
        check("b2b_last_pix", 32'(last_pix), 32'd128);
`endif

        // Reset asserted mid-frame: immediate return to reset values, partial frame dropped.
        start_frame(8'd108);
        drive_lines(3, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_thr", 32'(thr), 32'd64);
        check("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_lines(2, 0);
        @(negedge clk);
        vsync = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_no_done", 32'(done), 32'd0);
        end
        start_frame(8'd64);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
